// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-side PC / branch unit.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int PC_W_DEFAULT      = 10;
  localparam int LUT_IDX_W_DEFAULT = 5;
  localparam int N_TARGETS         = 8;

  // Absolute branch targets; LUT indices beyond this table resolve to 0.
  localparam int unsigned BRANCH_TARGETS [N_TARGETS] = '{
    16, 24, 32, 40, 7, 100, 511, 1023
  };

endpackage

// File: rtl/branch_target_lut.sv
// Combinational ROM mapping an instruction immediate to an absolute branch target.
module branch_target_lut
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int LUT_IDX_W = LUT_IDX_W_DEFAULT
) (
  input  logic [LUT_IDX_W-1:0] lut_idx,
  output logic [PC_W-1:0]      target
);

  // NOTE: assign a default before the case so every path drives target and no latch is inferred.
  always_comb begin
    target = '0;
    case (lut_idx)
      LUT_IDX_W'(0): target = PC_W'(BRANCH_TARGETS[0]);
      LUT_IDX_W'(1): target = PC_W'(BRANCH_TARGETS[1]);
      LUT_IDX_W'(2): target = PC_W'(BRANCH_TARGETS[2]);
      LUT_IDX_W'(3): target = PC_W'(BRANCH_TARGETS[3]);
      LUT_IDX_W'(4): target = PC_W'(BRANCH_TARGETS[4]);
      LUT_IDX_W'(5): target = PC_W'(BRANCH_TARGETS[5]);
      LUT_IDX_W'(6): target = PC_W'(BRANCH_TARGETS[6]);
      LUT_IDX_W'(7): target = PC_W'(BRANCH_TARGETS[7]);
      default:       target = '0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, carry flag and start/halt sequencing for the fetch stage
// downstream of the ALU; branch targets come from branch_target_lut.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int LUT_IDX_W = LUT_IDX_W_DEFAULT,
  parameter int START_PC  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 branch_en,
  input  logic                 branch_flag,
  input  logic                 abs_jump,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  logic                 halt_req,
  input  logic                 carry_we,
  input  logic                 carry_clr,
  input  logic                 carry_d,
  output logic                 carry_q,
  output logic [PC_W-1:0]      pc,
  output logic                 branch_taken,
  output logic                 done
);

  pc_state_t       state, state_next;
  logic [PC_W-1:0] pc_next, target;
  logic            carry_next, taken_next;

  branch_target_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_lut (
    .lut_idx (lut_idx),
    .target  (target)
  );

  always_comb begin
    state_next = state;
    pc_next    = pc;
    carry_next = carry_q;
    taken_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = PC_W'(START_PC);
        end
      end
      RUN: begin
        // Carry updates on every RUN cycle, including the halting one.
        if (carry_clr)     carry_next = 1'b0;
        else if (carry_we) carry_next = carry_d;

        if (halt_req) begin
          state_next = HALT;
        end else if (abs_jump || (branch_en && branch_flag)) begin
          pc_next    = target;
          taken_next = 1'b1;
        end else begin
          pc_next = pc + PC_W'(1);
        end
      end
      HALT: begin
        if (start) begin
          state_next = RUN;
          pc_next    = PC_W'(START_PC);
          carry_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= PC_W'(START_PC);
      carry_q      <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      carry_q      <= carry_next;
      branch_taken <= taken_next;
      done         <= (state_next == HALT);
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed vector table, a wrap/reset
// sequence, then randomized stimulus against a behavioural model (PC_W=10 and PC_W=4).
module tb_pc_branch_unit;

  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset, start, branch_en, branch_flag, abs_jump, halt_req;
  logic          carry_we, carry_clr, carry_d;
  logic [LW-1:0] lut_idx;
  logic          carry_q_a, taken_a, done_a, carry_q_b, taken_b, done_b;
  logic [9:0]    pc_a;
  logic [3:0]    pc_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_branch_unit #(.PC_W(10), .LUT_IDX_W(LW), .START_PC(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .branch_en(branch_en),
    .branch_flag(branch_flag), .abs_jump(abs_jump), .lut_idx(lut_idx),
    .halt_req(halt_req), .carry_we(carry_we), .carry_clr(carry_clr),
    .carry_d(carry_d), .carry_q(carry_q_a), .pc(pc_a),
    .branch_taken(taken_a), .done(done_a)
  );

  pc_branch_unit #(.PC_W(4), .LUT_IDX_W(LW), .START_PC(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .branch_en(branch_en),
    .branch_flag(branch_flag), .abs_jump(abs_jump), .lut_idx(lut_idx),
    .halt_req(halt_req), .carry_we(carry_we), .carry_clr(carry_clr),
    .carry_d(carry_d), .carry_q(carry_q_b), .pc(pc_b),
    .branch_taken(taken_b), .done(done_b)
  );

  // ---------------- behavioural model ----------------
  int tgt [32];
  int width [2] = '{10, 4};
  bit m_running, m_halted, m_carry, m_taken;
  int m_pc [2];

  task automatic model_step();
    bit redirect;
    redirect = abs_jump || (branch_en && branch_flag);
    if (reset) begin
      m_running = 0; m_halted = 0; m_carry = 0; m_taken = 0;
      m_pc = '{0, 0};
    end else if (m_running) begin
      m_carry = carry_clr ? 1'b0 : (carry_we ? carry_d : m_carry);
      m_taken = 0;
      if (halt_req) begin
        m_running = 0; m_halted = 1;
      end else begin
        for (int k = 0; k < 2; k++)
          m_pc[k] = (redirect ? tgt[lut_idx] : m_pc[k] + 1) % (1 << width[k]);
        m_taken = redirect;
      end
    end else begin
      m_taken = 0;
      if (start) begin
        if (m_halted) m_carry = 0;
        m_running = 1; m_halted = 0;
        m_pc = '{0, 0};
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit st, input bit ben, input bit bfl,
                       input bit abj, input int idx, input bit hlt,
                       input bit cwe, input bit ccl, input bit cd);
    reset = rst; start = st; branch_en = ben; branch_flag = bfl; abs_jump = abj;
    lut_idx = LW'(idx); halt_req = hlt; carry_we = cwe; carry_clr = ccl; carry_d = cd;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, st, ben, bfl, abj, hlt, cwe, ccl, cd;
    int idx;
    int e_pc, e_taken, e_done, e_carry;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(bit rst, bit st, bit ben, bit bfl, bit abj, int idx,
                               bit hlt, bit cwe, bit ccl, bit cd,
                               int e_pc, int e_taken, int e_done, int e_carry);
    vec_t v;
    v.rst = rst; v.st = st; v.ben = ben; v.bfl = bfl; v.abj = abj; v.idx = idx;
    v.hlt = hlt; v.cwe = cwe; v.ccl = ccl; v.cd = cd;
    v.e_pc = e_pc; v.e_taken = e_taken; v.e_done = e_done; v.e_carry = e_carry;
    return v;
  endfunction

  initial begin
    foreach (tgt[i]) tgt[i] = 0;
    tgt[0] = 16; tgt[1] = 24; tgt[2] = 32; tgt[3] = 40;
    tgt[4] = 7;  tgt[5] = 100; tgt[6] = 511; tgt[7] = 1023;

    //               rst st ben bfl abj idx hlt cwe ccl cd   pc tk dn cy
    vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0)); // reset
    vecs.push_back(row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0)); // start
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    2, 0, 0, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    3, 0, 0, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    4, 0, 0, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    5, 0, 0, 0));
    vecs.push_back(row(0, 0, 1, 1, 0, 3, 0, 0, 0, 0,   40, 1, 0, 0)); // taken branch
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   41, 0, 0, 0));
    vecs.push_back(row(0, 0, 0, 0, 1, 4, 0, 0, 0, 0,    7, 1, 0, 0)); // jump to 7
    vecs.push_back(row(0, 0, 1, 0, 0, 3, 0, 0, 0, 0,    8, 0, 0, 0)); // not taken
    vecs.push_back(row(0, 0, 0, 0, 1, 3, 0, 0, 0, 0,   40, 1, 0, 0)); // abs jump
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,   41, 0, 0, 1)); // carry write
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,   42, 0, 0, 0)); // clr wins
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,   43, 0, 0, 1));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   44, 0, 0, 1)); // carry holds
    vecs.push_back(row(0, 0, 0, 0, 1, 3, 1, 0, 0, 0,   44, 0, 1, 1)); // halt beats jump
    vecs.push_back(row(0, 0, 1, 1, 1, 3, 1, 0, 1, 0,   44, 0, 1, 1)); // HALT ignores ctrl
    vecs.push_back(row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0)); // restart
    vecs.push_back(row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0)); // start ignored in RUN
    vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0)); // reset mid-RUN
    vecs.push_back(row(0, 0, 0, 0, 1, 3, 0, 1, 0, 1,    0, 0, 0, 0)); // IDLE ignores ctrl
    vecs.push_back(row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0)); // start

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].ben, vecs[i].bfl, vecs[i].abj,
            vecs[i].idx, vecs[i].hlt, vecs[i].cwe, vecs[i].ccl, vecs[i].cd);
      step();
      check($sformatf("vec%0d pc", i),    int'(pc_a),      vecs[i].e_pc);
      check($sformatf("vec%0d taken", i), int'(taken_a),   vecs[i].e_taken);
      check($sformatf("vec%0d done", i),  int'(done_a),    vecs[i].e_done);
      check($sformatf("vec%0d carry", i), int'(carry_q_a), vecs[i].e_carry);
    end

    // PC_W=4 wraps 15 -> 0 silently; then run the wide PC up to 20 and reset.
    for (int n = 1; n <= 16; n++) begin
      nop();
      check($sformatf("wrap4 pc step%0d", n), int'(pc_b), n % 16);
      check($sformatf("wrap4 taken step%0d", n), int'(taken_b), 0);
    end
    check("pc10 after 16", int'(pc_a), 16);
    repeat (4) nop();
    check("pc10 at 20", int'(pc_a), 20);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("reset@20 pc", int'(pc_a), 0);
    check("reset@20 done", int'(done_a), 0);
    nop();
    check("idle after reset holds pc", int'(pc_a), 0);
    nop();
    check("idle after reset still 0", int'(pc_a), 0);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 64) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0,
            $urandom % 2, ($urandom % 8) == 0,
            ($urandom % 2) ? int'($urandom % 8) : int'($urandom % 32),
            ($urandom % 16) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
            $urandom % 2);
      step();
      check("rnd pc10",    int'(pc_a),      m_pc[0]);
      check("rnd pc4",     int'(pc_b),      m_pc[1]);
      check("rnd taken10", int'(taken_a),   int'(m_taken));
      check("rnd taken4",  int'(taken_b),   int'(m_taken));
      check("rnd done10",  int'(done_a),    int'(m_halted));
      check("rnd done4",   int'(done_b),    int'(m_halted));
      check("rnd carry10", int'(carry_q_a), int'(m_carry));
      check("rnd carry4",  int'(carry_q_b), int'(m_carry));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
